// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone definitions for the two-master arbiter: bus widths, FSM
// state encodings and per-master port macros live here as the common
// Wishbone include; the package wraps them in typed form for the RTL.
`ifndef WB_DEFINES_SVH
`define WB_DEFINES_SVH

`define DAT_WIDTH 64
`define SEL_WIDTH (`DAT_WIDTH/8)

`define WB_ST_IDLE   2'd0
`define WB_ST_GRANT0 2'd1
`define WB_ST_GRANT1 2'd2
`define WB_ST_ABORT  2'd3

`define WB_M0_SIGS \
    logic                  m0_cyc_i; \
    logic                  m0_stb_i; \
    logic                  m0_we_i; \
    logic [`DAT_WIDTH-1:0] m0_adr_i; \
    logic [`SEL_WIDTH-1:0] m0_sel_i; \
    logic [`DAT_WIDTH-1:0] m0_dat_i; \
    logic [`DAT_WIDTH-1:0] m0_dat_o; \
    logic                  m0_ack_o; \
    logic                  m0_err_o;

`define WB_M1_SIGS \
    logic                  m1_cyc_i; \
    logic                  m1_stb_i; \
    logic                  m1_we_i; \
    logic [`DAT_WIDTH-1:0] m1_adr_i; \
    logic [`SEL_WIDTH-1:0] m1_sel_i; \
    logic [`DAT_WIDTH-1:0] m1_dat_i; \
    logic [`DAT_WIDTH-1:0] m1_dat_o; \
    logic                  m1_ack_o; \
    logic                  m1_err_o;

`define WB_M0_SLAVE_MP \
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i, \
    output m0_dat_o, m0_ack_o, m0_err_o

`define WB_M1_SLAVE_MP \
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i, \
    output m1_dat_o, m1_ack_o, m1_err_o

`define WB_M0_MASTER_MP \
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i, \
    input  m0_dat_o, m0_ack_o, m0_err_o

`define WB_M1_MASTER_MP \
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i, \
    input  m1_dat_o, m1_ack_o, m1_err_o

`endif

package wb_arbiter_pkg;

    localparam int DAT_W  = `DAT_WIDTH;
    localparam int SEL_W  = `SEL_WIDTH;
    localparam int WDOG_W = 8;

    typedef enum logic [1:0] {
        IDLE   = `WB_ST_IDLE,
        GRANT0 = `WB_ST_GRANT0,
        GRANT1 = `WB_ST_GRANT1,
        ABORT  = `WB_ST_ABORT
    } arb_state_e;

    // One-hot grant vector for a master index.
    function automatic logic [1:0] grant_vec(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Grant state for a master index.
    function automatic arb_state_e grant_state(input logic idx);
        return idx ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle around the arbiter: both master ports plus the shared slave
// port. The "slave" modport is the arbiter's view (it serves the masters),
// the "master" modport is the view of whatever drives the masters and
// models the slave.
interface wb_arbiter_if;

    `WB_M0_SIGS
    `WB_M1_SIGS

    logic                  s_cyc_o;
    logic                  s_stb_o;
    logic                  s_we_o;
    logic [`DAT_WIDTH-1:0] s_adr_o;
    logic [`SEL_WIDTH-1:0] s_sel_o;
    logic [`DAT_WIDTH-1:0] s_dat_o;
    logic [`DAT_WIDTH-1:0] s_dat_i;
    logic                  s_ack_i;
    logic                  s_err_i;

    modport slave (
        `WB_M0_SLAVE_MP,
        `WB_M1_SLAVE_MP,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        input  s_dat_i, s_ack_i, s_err_i
    );

    modport master (
        `WB_M0_MASTER_MP,
        `WB_M1_MASTER_MP,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        output s_dat_i, s_ack_i, s_err_i
    );

endinterface

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts consecutive strobe cycles without a slave response
// and flags expiry on the cycle the count reaches TIMEOUT-1. TIMEOUT = 0
// disables it. Usable on any Wishbone segment.
module wb_watchdog
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stb,
    input  logic ack,
    input  logic err,
    output logic expired
);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;
    logic              quiet;

    // Any cycle without an outstanding strobe, or with a response, restarts the count.
    assign quiet = !stb || ack || err;

    // Next count: clear when quiet, otherwise one more waiting cycle.
    always_comb begin
        cnt_d = quiet ? '0 : cnt_q + WDOG_W'(1);
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);
            // A response in the limit cycle wins over expiry.
            assign expired = !quiet && (cnt_q == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with round-robin tie break, whole-cycle grant
// hold, and a watchdog that errors out and aborts a stalled transfer.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_arbiter_if.slave bus,
    output logic [1:0]  gnt_o
);

    arb_state_e state_q;
    logic       last_q;     // master granted most recently
    logic       abort_q;    // master whose transfer was aborted
    logic [1:0] gnt_q;
    logic       grant0;
    logic       grant1;
    logic       wdog_expired;

    assign grant0 = (state_q == GRANT0);
    assign grant1 = (state_q == GRANT1);
    assign gnt_o  = gnt_q;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stb     (bus.s_stb_o),
        .ack     (bus.s_ack_i),
        .err     (bus.s_err_i),
        .expired (wdog_expired)
    );

    // Arbitration FSM; gnt_q is registered alongside the state so the
    // visible grant never depends on the current request inputs.
    // gnt_q keeps showing the aborted master during ABORT until it lets go.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            abort_q <= 1'b0;
            gnt_q   <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                        state_q <= grant_state(!last_q);
                        gnt_q   <= grant_vec(!last_q);
                    end else if (bus.m0_cyc_i) begin
                        state_q <= GRANT0;
                        gnt_q   <= grant_vec(1'b0);
                    end else if (bus.m1_cyc_i) begin
                        state_q <= GRANT1;
                        gnt_q   <= grant_vec(1'b1);
                    end
                end
                GRANT0: begin
                    if (wdog_expired) begin
                        state_q <= ABORT;
                        abort_q <= 1'b0;
                    end else if (!bus.m0_cyc_i) begin
                        state_q <= IDLE;
                        last_q  <= 1'b0;
                        gnt_q   <= 2'b00;
                    end
                end
                GRANT1: begin
                    if (wdog_expired) begin
                        state_q <= ABORT;
                        abort_q <= 1'b1;
                    end else if (!bus.m1_cyc_i) begin
                        state_q <= IDLE;
                        last_q  <= 1'b1;
                        gnt_q   <= 2'b00;
                    end
                end
                ABORT: begin
                    if (!(abort_q ? bus.m1_cyc_i : bus.m0_cyc_i)) begin
                        state_q <= IDLE;
                        last_q  <= abort_q;
                        gnt_q   <= 2'b00;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    // Slave request mux: a straight copy of the granted master, quiet otherwise.
    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_sel_o = '0;
        bus.s_dat_o = '0;
        if (grant0) begin
            bus.s_cyc_o = bus.m0_cyc_i;
            bus.s_stb_o = bus.m0_stb_i;
            bus.s_we_o  = bus.m0_we_i;
            bus.s_adr_o = bus.m0_adr_i;
            bus.s_sel_o = bus.m0_sel_i;
            bus.s_dat_o = bus.m0_dat_i;
        end else if (grant1) begin
            bus.s_cyc_o = bus.m1_cyc_i;
            bus.s_stb_o = bus.m1_stb_i;
            bus.s_we_o  = bus.m1_we_i;
            bus.s_adr_o = bus.m1_adr_i;
            bus.s_sel_o = bus.m1_sel_i;
            bus.s_dat_o = bus.m1_dat_i;
        end
    end

    // Read data is broadcast; ack/err only reach the master actively granted.
    // Watchdog expiry shows up as a one-cycle err to that master.
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;
    assign bus.m0_ack_o = grant0 & bus.s_ack_i;
    assign bus.m1_ack_o = grant1 & bus.s_ack_i;
    assign bus.m0_err_o = grant0 & (bus.s_err_i | wdog_expired);
    assign bus.m1_err_o = grant1 & (bus.s_err_i | wdog_expired);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for single-master, tie and
// fairness traffic, plus hand sequences for block hold, timeout and reset.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam logic [63:0] A0   = 64'h0000_8000_0000_0000;
    localparam logic [63:0] A1   = 64'h0000_0000_0000_1000;
    localparam logic [63:0] RDAT = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] WD0  = 64'h1111_1111_1111_1111;
    localparam logic [63:0] WD1  = 64'h2222_3333_4444_5555;
    localparam logic [63:0] N0   = 64'h0;
    localparam logic        L    = 1'b0;
    localparam logic        H    = 1'b1;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [1:0] gnt_o;
    int         checks = 0;
    int         errors = 0;

    wb_arbiter_if bus();

    wb_arbiter #(
        .TIMEOUT (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus),
        .gnt_o (gnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, c0, s0, c1, s1, ack, err;
        logic [1:0]  gnt;
        logic        scyc, sstb;
        logic [63:0] sadr;
        logic        a0, e0, a1, e1;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, c0, s0, c1, s1, ack, err,
                                input logic [1:0] gnt, input logic scyc, sstb,
                                input logic [63:0] sadr, input logic a0, e0, a1, e1);
        vec_t v;
        v.rst = rst; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack; v.err = err;
        v.gnt = gnt; v.scyc = scyc; v.sstb = sstb; v.sadr = sadr;
        v.a0 = a0; v.e0 = e0; v.a1 = a1; v.e1 = e1;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, c0, s0, c1, s1, ack, err);
        rst_i        = rst;
        bus.m0_cyc_i = c0;
        bus.m0_stb_i = s0;
        bus.m1_cyc_i = c1;
        bus.m1_stb_i = s1;
        bus.s_ack_i  = ack;
        bus.s_err_i  = err;
        bus.s_dat_i  = ack ? RDAT : N0;
    endtask

    // Drive inputs for this cycle and let combinational outputs settle.
    task automatic step(input logic rst, c0, s0, c1, s1, ack, err);
        drive(rst, c0, s0, c1, s1, ack, err);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_resp(input string tag, input logic a0, e0, a1, e1);
        chk1({tag, " m0_ack"}, bus.m0_ack_o, a0);
        chk1({tag, " m0_err"}, bus.m0_err_o, e0);
        chk1({tag, " m1_ack"}, bus.m1_ack_o, a1);
        chk1({tag, " m1_err"}, bus.m1_err_o, e1);
    endtask

    initial begin
        #200000;
        $display("FAIL time_limit: simulation still running at %0t, expected end well before", $time);
        $fatal(1);
    end

    initial begin
        bus.m0_we_i  = 1'b0;
        bus.m0_adr_i = A0;
        bus.m0_sel_i = 8'hFF;
        bus.m0_dat_i = WD0;
        bus.m1_we_i  = 1'b1;
        bus.m1_adr_i = A1;
        bus.m1_sel_i = 8'h0F;
        bus.m1_dat_i = WD1;

        // rst, c0,s0, c1,s1, ack,err, gnt, s_cyc,s_stb, s_adr, ack0,err0,ack1,err1
        // Single master read, slave acks in the third granted cycle.
        vq.push_back(mk(H, L,L, L,L, L,L, 2'b00, L,L, N0, L,L,L,L));
        vq.push_back(mk(H, H,H, L,L, L,L, 2'b00, L,L, N0, L,L,L,L));
        vq.push_back(mk(H, H,H, L,L, L,L, 2'b01, H,H, A0, L,L,L,L));
        vq.push_back(mk(H, H,H, L,L, L,L, 2'b01, H,H, A0, L,L,L,L));
        vq.push_back(mk(H, H,H, L,L, H,L, 2'b01, H,H, A0, H,L,L,L));
        vq.push_back(mk(H, L,L, L,L, L,L, 2'b01, L,L, A0, L,L,L,L));
        vq.push_back(mk(H, L,L, L,L, L,L, 2'b00, L,L, N0, L,L,L,L));
        // Reset, then a tie: m0 first, one IDLE cycle, then m1.
        vq.push_back(mk(L, L,L, L,L, L,L, 2'b00, L,L, N0, L,L,L,L));
        vq.push_back(mk(H, H,H, H,H, L,L, 2'b00, L,L, N0, L,L,L,L));
        vq.push_back(mk(H, H,H, H,H, H,L, 2'b01, H,H, A0, H,L,L,L));
        vq.push_back(mk(H, L,L, H,H, L,L, 2'b01, L,L, A0, L,L,L,L));
        vq.push_back(mk(H, L,L, H,H, L,L, 2'b00, L,L, N0, L,L,L,L));
        vq.push_back(mk(H, L,L, H,H, H,L, 2'b10, H,H, A1, L,L,H,L));
        vq.push_back(mk(H, L,L, L,L, L,L, 2'b10, L,L, A1, L,L,L,L));
        vq.push_back(mk(H, L,L, L,L, L,L, 2'b00, L,L, N0, L,L,L,L));
        // Fairness: three single transfers each, grants alternate.
        for (int r = 0; r < 3; r++) begin
            vq.push_back(mk(H, H,H, H,H, L,L, 2'b00, L,L, N0, L,L,L,L));
            vq.push_back(mk(H, H,H, H,H, H,L, 2'b01, H,H, A0, H,L,L,L));
            vq.push_back(mk(H, L,L, H,H, L,L, 2'b01, L,L, A0, L,L,L,L));
            vq.push_back(mk(H, H,H, H,H, L,L, 2'b00, L,L, N0, L,L,L,L));
            if (r < 2) begin
                vq.push_back(mk(H, H,H, H,H, H,L, 2'b10, H,H, A1, L,L,H,L));
                vq.push_back(mk(H, H,H, L,L, L,L, 2'b10, L,L, A1, L,L,L,L));
            end else begin
                // Last m1 transfer ends in a slave error instead of an ack.
                vq.push_back(mk(H, H,H, H,H, L,H, 2'b10, H,H, A1, L,L,L,H));
                vq.push_back(mk(H, L,L, L,L, L,L, 2'b10, L,L, A1, L,L,L,L));
            end
        end
        vq.push_back(mk(H, L,L, L,L, L,L, 2'b00, L,L, N0, L,L,L,L));

        drive(L, L,L, L,L, L,L);
        tick();
        tick();

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].c0, vq[i].s0, vq[i].c1, vq[i].s1, vq[i].ack, vq[i].err);
            chk2($sformatf("v%0d gnt", i), gnt_o, vq[i].gnt);
            chk1($sformatf("v%0d s_cyc", i), bus.s_cyc_o, vq[i].scyc);
            chk1($sformatf("v%0d s_stb", i), bus.s_stb_o, vq[i].sstb);
            chk64($sformatf("v%0d s_adr", i), bus.s_adr_o, vq[i].sadr);
            chk_resp($sformatf("v%0d", i), vq[i].a0, vq[i].e0, vq[i].a1, vq[i].e1);
            if (vq[i].ack) begin
                chk64($sformatf("v%0d m0_dat", i), bus.m0_dat_o, RDAT);
                chk64($sformatf("v%0d m1_dat", i), bus.m1_dat_o, RDAT);
            end
            $display("vec %0d: gnt=%b s_cyc=%b s_stb=%b ack=%b%b err=%b%b", i, gnt_o,
                     bus.s_cyc_o, bus.s_stb_o, bus.m1_ack_o, bus.m0_ack_o,
                     bus.m1_err_o, bus.m0_err_o);
            tick();
        end

        // Block hold: m1 owns the bus for 4 acked strobes while m0 waits.
        step(H, L,L, H,H, L,L);
        chk2("hold req gnt", gnt_o, 2'b00);
        tick();
        for (int k = 0; k < 4; k++) begin
            step(H, H,H, H,H, H,L);
            chk2($sformatf("hold%0d gnt", k), gnt_o, 2'b10);
            chk_resp($sformatf("hold%0d", k), L, L, H, L);
            chk1($sformatf("hold%0d s_we", k), bus.s_we_o, H);
            chk64($sformatf("hold%0d s_dat", k), bus.s_dat_o, WD1);
            $display("hold %0d: gnt=%b ack1=%b ack0=%b", k, gnt_o, bus.m1_ack_o, bus.m0_ack_o);
            tick();
        end
        step(H, H,H, L,L, L,L);
        chk2("hold release gnt", gnt_o, 2'b10);
        tick();
        step(H, H,H, L,L, L,L);
        chk2("hold idle gnt", gnt_o, 2'b00);
        tick();
        step(H, H,H, L,L, L,L);
        chk2("hold m0 gnt", gnt_o, 2'b01);
        chk1("hold m0 s_we", bus.s_we_o, L);
        chk64("hold m0 s_dat", bus.s_dat_o, WD0);
        tick();
        step(H, L,L, L,L, L,L);
        tick();
        step(H, L,L, L,L, L,L);
        tick();

        // Timeout: slave never answers; err in the 16th strobe cycle, then ABORT.
        step(H, H,H, L,L, L,L);
        tick();
        for (int k = 1; k <= 16; k++) begin
            step(H, H,H, L,L, L,L);
            chk1($sformatf("to%0d s_stb", k), bus.s_stb_o, H);
            chk_resp($sformatf("to%0d", k), L, (k == 16), L, L);
            $display("timeout cycle %0d: err0=%b", k, bus.m0_err_o);
            tick();
        end
        step(H, H,H, L,L, L,L);
        chk1("abort s_stb", bus.s_stb_o, L);
        chk1("abort s_cyc", bus.s_cyc_o, L);
        chk2("abort gnt", gnt_o, 2'b01);
        chk_resp("abort", L, L, L, L);
        tick();
        step(H, L,L, L,L, L,L);
        chk2("abort drop gnt", gnt_o, 2'b01);
        tick();
        step(H, L,L, L,L, L,L);
        chk2("abort idle gnt", gnt_o, 2'b00);
        tick();

        // Ack arriving in the 16th strobe cycle beats the watchdog.
        step(H, H,H, L,L, L,L);
        tick();
        for (int k = 1; k <= 16; k++) begin
            step(H, H,H, L,L, (k == 16), L);
            chk_resp($sformatf("late%0d", k), (k == 16), L, L, L);
            $display("late ack cycle %0d: ack0=%b err0=%b", k, bus.m0_ack_o, bus.m0_err_o);
            tick();
        end
        step(H, H,H, L,L, L,L);
        chk2("late after gnt", gnt_o, 2'b01);
        chk1("late after s_stb", bus.s_stb_o, H);
        chk_resp("late after", L, L, L, L);
        tick();
        step(H, L,L, L,L, L,L);
        tick();
        step(H, L,L, L,L, L,L);
        tick();

        // Reset while m1 holds the bus with a strobe pending.
        step(H, L,L, H,H, L,L);
        tick();
        step(H, L,L, H,H, L,L);
        chk2("rst pre gnt", gnt_o, 2'b10);
        chk1("rst pre s_stb", bus.s_stb_o, H);
        tick();
        step(L, L,L, H,H, L,L);
        chk_resp("rst edge", L, L, L, L);
        tick();
        step(L, H,H, H,H, L,L);
        chk1("rst s_cyc", bus.s_cyc_o, L);
        chk1("rst s_stb", bus.s_stb_o, L);
        chk2("rst gnt", gnt_o, 2'b00);
        chk_resp("rst", L, L, L, L);
        tick();
        step(H, H,H, H,H, L,L);
        chk2("post rst idle gnt", gnt_o, 2'b00);
        tick();
        step(H, H,H, H,H, L,L);
        chk2("post rst tie gnt", gnt_o, 2'b01);
        chk64("post rst s_adr", bus.s_adr_o, A0);
        $display("reset sequence: first grant after reset gnt=%b", gnt_o);
        tick();
        step(H, L,L, L,L, L,L);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
